soc_bus_decoder: RTL and testbench
==================================

Name: soc_bus_decoder

Overview:
- Parametrised decoder and handshake controller for the picorv32 native memory bus in our iCE40 control SoCs.
- Replaces hard-coded per-SoC address decode with NSLV mask/base regions, each of which can be marked read-only.
- Each selected slave gets a valid/ready handshake; the decoder returns registered read data to the CPU.
- Raises a sticky buserror on an unmapped access, a write to a read-only region, or a slave that does not respond (timeout).

Parameters:
- NSLV, 4: number of slave regions (1..16).
- BASE, {NSLV{32'h0}}: packed NSLV*32 region base addresses; region i is BASE[32*i+:32].
- MASK, {NSLV{32'hFFFFFFFF}}: packed NSLV*32 compare masks; region i matches when (mem_addr & MASK_i) == BASE_i.
- RO, {NSLV{1'b0}}: per-region read-only flag.
- TIMEOUT, 255: maximum number of WAIT cycles without s_ready; 0 disables the timeout.
- TW, 8: timeout counter width; TIMEOUT must be < 2**TW.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous reset, active-low.
- mem_valid  in  1  CPU request.
- mem_addr  in  32  CPU address.
- mem_wdata  in  32  CPU write data.
- mem_wstrb  in  4  CPU byte write strobes; 0 means read.
- mem_ready  out  1  one-cycle completion pulse to the CPU.
- mem_rdata  out  32  registered read data.
- s_valid  out  NSLV  one-hot request to the selected slave.
- s_addr  out  32  mem_addr, broadcast combinationally.
- s_wdata  out  32  mem_wdata, broadcast combinationally.
- s_wstrb  out  4  mem_wstrb, broadcast combinationally.
- s_ready  in  NSLV  per-slave completion.
- s_rdata  in  NSLV*32  packed per-slave read data.
- buserror  out  1  sticky bus error flag.

Behaviour:
- Reset values (synchronous, resetn low): state IDLE, mem_ready 0, mem_rdata 0, s_valid 0, buserror 0, timeout counter 0.
- A reset asserted mid-transaction aborts it. No mem_ready is issued for the aborted transaction.
- Region priority: when regions overlap, the lowest matching index wins.

State machine (IDLE, WAIT, DONE, ERROR):
- IDLE, on mem_valid && !buserror, decoding in the same cycle:
  - No region matches → ERROR.
  - Matched region has RO=1 and |mem_wstrb → ERROR.
  - Otherwise, next cycle: s_valid[i]=1, counter cleared, state WAIT.
- WAIT:
  - s_valid[i] is held high. The CPU holds mem_* stable.
  - s_ready[i] high at cycle t → at t+1: mem_rdata = s_rdata[i] (reads and writes alike), mem_ready=1, s_valid=0, state DONE.
  - s_ready bits of non-selected slaves, and any s_ready while s_valid is low, are ignored.
  - Each cycle without s_ready[i] increments the counter.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without s_ready → next cycle: s_valid=0, state ERROR, no mem_ready.
- DONE:
  - mem_ready is high for exactly this one cycle; next cycle mem_ready=0 and state IDLE.
  - mem_valid is not re-decoded during DONE.
- ERROR:
  - buserror=1 and stays set until reset.
  - No further mem_ready is ever issued and s_valid stays 0, so the CPU stalls.
- Latency: minimum 2 cycles from mem_valid sampled in IDLE to mem_ready, assuming a combinational s_ready.
- Wrap-around: the counter saturates and never wraps. TIMEOUT=2**TW-1 is legal.

Optional Feature:
- Macro: SOC_BUS_ERR_CAPTURE_EN.
- When defined, two extra outputs are added:
  - err_addr (32): mem_addr of the faulting access.
  - err_cause (2): 0 none, 1 unmapped, 2 read-only write, 3 timeout.
- Both are captured on the cycle the FSM enters ERROR, hold until reset, and reset to 0.
- When not defined, these ports and registers do not exist.

Decomposition:
- Package soc_bus_pkg holds:
  - the state typedef (IDLE/WAIT/DONE/ERROR);
  - the err_cause constants;
  - the helper function region_hit(addr, base, mask).
- One sub-module, soc_bus_region_match: combinational priority encoder taking mem_addr, BASE, MASK and RO, producing hit, idx and ro.

Test Plan:
- Bench configuration: NSLV=3; R0 = 0x0/0xFFFF0000; R1 = 0x10000/0xFFFF0000; R2 = 0x100000/0xFFF00000 with RO; TIMEOUT=16.
- Read 0x00000004, slave 0 ready in the same cycle returning 0xDEADBEEF → mem_ready at cycle 2, mem_rdata=0xDEADBEEF, s_valid=3'b001 for exactly 1 cycle.
- Write 0x00010008 with wstrb=4'b0011, slave 1 ready after 5 wait cycles → s_valid[1] high 6 cycles, single mem_ready pulse, buserror 0.
- Write 0x00100000 with wstrb=4'b1111 → no s_valid, no mem_ready, buserror=1 next cycle; err_cause=2 and err_addr=0x00100000 when SOC_BUS_ERR_CAPTURE_EN is defined.
- Read 0x02000000 (unmapped) → buserror=1, err_cause=1. A following valid request gets no response.
- Read 0x00000000 with slave 0 never ready → s_valid drops after 16 cycles, buserror=1, err_cause=3. Pulsing s_ready[1] during the wait has no effect.
- Assert resetn=0 while in WAIT → next cycle s_valid=0, buserror=0, state IDLE. A following read completes normally.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared types for the picorv32 native-bus decoder: FSM states, error
// cause codes and the region compare helper.
package soc_bus_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERROR} state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_UNMAPPED = 2'd1;
  localparam logic [1:0] ERR_RO       = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/soc_bus_region_match.sv
// Combinational address decode over NSLV mask/base regions.
// Overlapping regions resolve to the lowest matching index.
module soc_bus_region_match import soc_bus_pkg::*; #(
  parameter int                 NSLV = 4,
  parameter int                 IW   = 2,
  parameter logic [NSLV*32-1:0] BASE = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] MASK = {NSLV{32'hFFFFFFFF}},
  parameter logic [NSLV-1:0]    RO   = {NSLV{1'b0}}
) (
  input  logic [31:0]   mem_addr,
  output logic          hit,
  output logic [IW-1:0] idx,
  output logic          ro
);

  logic [NSLV-1:0] hit_vec;

  for (genvar i = 0; i < NSLV; i++) begin : g_rgn
    assign hit_vec[i] = region_hit(mem_addr, BASE[32*i +: 32], MASK[32*i +: 32]);
  end

  // Scan high-to-low so a lower-index hit overwrites any higher one.
  always_comb begin
    hit = |hit_vec;
    idx = '0;
    ro  = 1'b0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        idx = IW'(i);
        ro  = RO[i];
      end
    end
  end

endmodule

// File: rtl/soc_bus_decoder.sv
// picorv32 native-bus decoder / handshake controller with sticky bus error.
// Optional error capture (err_addr/err_cause) under SOC_BUS_ERR_CAPTURE_EN.
module soc_bus_decoder import soc_bus_pkg::*; #(
  parameter int                 NSLV    = 4,
  parameter logic [NSLV*32-1:0] BASE    = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] MASK    = {NSLV{32'hFFFFFFFF}},
  parameter logic [NSLV-1:0]    RO      = {NSLV{1'b0}},
  parameter int                 TIMEOUT = 255,
  parameter int                 TW      = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               mem_valid,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_wstrb,
  output logic               mem_ready,
  output logic [31:0]        mem_rdata,
  output logic [NSLV-1:0]    s_valid,
  output logic [31:0]        s_addr,
  output logic [31:0]        s_wdata,
  output logic [3:0]         s_wstrb,
  input  logic [NSLV-1:0]    s_ready,
  input  logic [NSLV*32-1:0] s_rdata,
  output logic               buserror
`ifdef SOC_BUS_ERR_CAPTURE_EN
  ,
  output logic [31:0]        err_addr,
  output logic [1:0]         err_cause
`endif
);

  localparam int             IW      = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [TW-1:0]  TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] cnt;
  logic [IW-1:0] sel;
  logic          hit, hit_ro;
  logic [IW-1:0] hit_idx;
  logic [1:0]    cause_nxt;
  logic          err_go;

  assign s_addr  = mem_addr;
  assign s_wdata = mem_wdata;
  assign s_wstrb = mem_wstrb;

  soc_bus_region_match #(
    .NSLV (NSLV), .IW (IW), .BASE (BASE), .MASK (MASK), .RO (RO)
  ) u_match (
    .mem_addr (mem_addr),
    .hit      (hit),
    .idx      (hit_idx),
    .ro       (hit_ro)
  );

  // Classify the fault (if any) that would move the FSM into ERROR this cycle.
  always_comb begin
    cause_nxt = ERR_NONE;
    if (state == IDLE && mem_valid && !buserror) begin
      if (!hit)                      cause_nxt = ERR_UNMAPPED;
      else if (hit_ro && |mem_wstrb) cause_nxt = ERR_RO;
    end else if (state == WAIT && !s_ready[sel] && TIMEOUT != 0 && cnt == TO_LAST) begin
      cause_nxt = ERR_TIMEOUT;
    end
  end

  assign err_go = (cause_nxt != ERR_NONE);

  // Request/handshake FSM; all CPU- and slave-facing controls are registered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      s_valid   <= '0;
      buserror  <= 1'b0;
      cnt       <= '0;
      sel       <= '0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (err_go) begin
            state    <= ERROR;
            buserror <= 1'b1;
          end else if (mem_valid && !buserror) begin
            s_valid <= NSLV'(1) << hit_idx;
            sel     <= hit_idx;
            cnt     <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (s_ready[sel]) begin
            mem_rdata <= s_rdata[32*sel +: 32];
            mem_ready <= 1'b1;
            s_valid   <= '0;
            state     <= DONE;
          end else if (err_go) begin
            s_valid  <= '0;
            buserror <= 1'b1;
            state    <= ERROR;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:  state <= IDLE;
        ERROR: begin
          buserror <= 1'b1;
          s_valid  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SOC_BUS_ERR_CAPTURE_EN
  // Latch address and cause of the first fault; held until reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_addr  <= '0;
      err_cause <= ERR_NONE;
    end else if (err_go) begin
      err_addr  <= mem_addr;
      err_cause <= cause_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_soc_bus_decoder.sv
// Directed bench for soc_bus_decoder: NSLV=3, R2 read-only, TIMEOUT=16.
module tb_soc_bus_decoder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [2:0]  s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_ready;
  logic [95:0] s_rdata;
  logic        buserror;
`ifdef SOC_BUS_ERR_CAPTURE_EN
  logic [31:0] err_addr;
  logic [1:0]  err_cause;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  soc_bus_decoder #(
    .NSLV    (3),
    .BASE    ({32'h0010_0000, 32'h0001_0000, 32'h0000_0000}),
    .MASK    ({32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
    .RO      (3'b100),
    .TIMEOUT (16),
    .TW      (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .s_valid   (s_valid),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .buserror  (buserror)
`ifdef SOC_BUS_ERR_CAPTURE_EN
    ,
    .err_addr  (err_addr),
    .err_cause (err_cause)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    s_ready   = '0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    s_rdata = '0;
    do_reset();
    resetn = 1'b0;
    tick();
    chk("rst_ready",  {31'b0, mem_ready}, 32'd0);
    chk("rst_rdata",  mem_rdata, 32'd0);
    chk("rst_svalid", {29'b0, s_valid}, 32'd0);
    chk("rst_berr",   {31'b0, buserror}, 32'd0);
`ifdef SOC_BUS_ERR_CAPTURE_EN
    chk("rst_eaddr",  err_addr, 32'd0);
    chk("rst_ecause", {30'b0, err_cause}, 32'd0);
`endif
    resetn = 1'b1;
    tick();

    // Read 0x4, slave 0 ready combinationally.
    mem_valid = 1'b1; mem_addr = 32'h0000_0004; mem_wstrb = 4'b0000;
    s_rdata[31:0] = 32'hDEAD_BEEF; s_ready = 3'b001;
    chk("rd0_saddr", s_addr, 32'h0000_0004);
    tick();
    chk("rd0_sv_c1", {29'b0, s_valid}, 32'b001);
    chk("rd0_rdy_c1", {31'b0, mem_ready}, 32'd0);
    tick();
    chk("rd0_rdy_c2", {31'b0, mem_ready}, 32'd1);
    chk("rd0_rdata",  mem_rdata, 32'hDEAD_BEEF);
    chk("rd0_sv_c2",  {29'b0, s_valid}, 32'b000);
    mem_valid = 1'b0; s_ready = 3'b000;
    tick();
    chk("rd0_rdy_c3", {31'b0, mem_ready}, 32'd0);

    // Write 0x10008, slave 1 ready after 5 wait cycles.
    tick();
    mem_valid = 1'b1; mem_addr = 32'h0001_0008; mem_wstrb = 4'b0011; mem_wdata = 32'hA5A5_0102;
    s_rdata[63:32] = 32'h1234_5678;
    tick();
    chk("wr1_sv0", {29'b0, s_valid}, 32'b010);
    chk("wr1_swd", s_wdata, 32'hA5A5_0102);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("wr1_sv%0d", k), {29'b0, s_valid}, 32'b010);
      chk($sformatf("wr1_rdy%0d", k), {31'b0, mem_ready}, 32'd0);
    end
    s_ready = 3'b010;
    tick();
    chk("wr1_rdy",   {31'b0, mem_ready}, 32'd1);
    chk("wr1_svoff", {29'b0, s_valid}, 32'b000);
    chk("wr1_rdata", mem_rdata, 32'h1234_5678);
    chk("wr1_berr",  {31'b0, buserror}, 32'd0);
    mem_valid = 1'b0; s_ready = 3'b000;
    tick();
    chk("wr1_rdy_off", {31'b0, mem_ready}, 32'd0);

    // Read from read-only region is permitted.
    tick();
    mem_valid = 1'b1; mem_addr = 32'h0010_0010; mem_wstrb = 4'b0000;
    s_rdata[95:64] = 32'h0BAD_F00D; s_ready = 3'b100;
    tick();
    chk("ro_rd_sv", {29'b0, s_valid}, 32'b100);
    tick();
    chk("ro_rd_rdy",   {31'b0, mem_ready}, 32'd1);
    chk("ro_rd_rdata", mem_rdata, 32'h0BAD_F00D);
    mem_valid = 1'b0; s_ready = 3'b000;
    tick();

    // Write to read-only region.
    mem_valid = 1'b1; mem_addr = 32'h0010_0000; mem_wstrb = 4'b1111;
    tick();
    chk("ro_wr_berr", {31'b0, buserror}, 32'd1);
    chk("ro_wr_sv",   {29'b0, s_valid}, 32'd0);
    chk("ro_wr_rdy",  {31'b0, mem_ready}, 32'd0);
`ifdef SOC_BUS_ERR_CAPTURE_EN
    chk("ro_wr_cause", {30'b0, err_cause}, 32'd2);
    chk("ro_wr_eaddr", err_addr, 32'h0010_0000);
`endif
    s_ready = 3'b111;
    tick();
    tick();
    chk("ro_wr_stall_sv",  {29'b0, s_valid}, 32'd0);
    chk("ro_wr_stall_rdy", {31'b0, mem_ready}, 32'd0);

    // Unmapped read, then a further request is ignored.
    do_reset();
    chk("post_rst_berr", {31'b0, buserror}, 32'd0);
    mem_valid = 1'b1; mem_addr = 32'h0200_0000; mem_wstrb = 4'b0000;
    tick();
    chk("um_berr", {31'b0, buserror}, 32'd1);
    chk("um_sv",   {29'b0, s_valid}, 32'd0);
`ifdef SOC_BUS_ERR_CAPTURE_EN
    chk("um_cause", {30'b0, err_cause}, 32'd1);
    chk("um_eaddr", err_addr, 32'h0200_0000);
`endif
    mem_valid = 1'b0;
    tick();
    mem_valid = 1'b1; mem_addr = 32'h0000_0004; s_ready = 3'b111;
    tick();
    tick();
    tick();
    chk("um_next_sv",   {29'b0, s_valid}, 32'd0);
    chk("um_next_rdy",  {31'b0, mem_ready}, 32'd0);
    chk("um_next_berr", {31'b0, buserror}, 32'd1);

    // Timeout on slave 0 while slave 1 toggles its ready.
    do_reset();
    mem_valid = 1'b1; mem_addr = 32'h0000_0000; mem_wstrb = 4'b0000;
    tick();
    chk("to_sv0", {29'b0, s_valid}, 32'b001);
    for (int k = 1; k <= 15; k++) begin
      s_ready = (k % 2 == 1) ? 3'b010 : 3'b000;
      tick();
      chk($sformatf("to_sv%0d", k), {29'b0, s_valid}, 32'b001);
      chk($sformatf("to_rdy%0d", k), {31'b0, mem_ready}, 32'd0);
      chk($sformatf("to_berr%0d", k), {31'b0, buserror}, 32'd0);
    end
    s_ready = 3'b010;
    tick();
    chk("to_sv_off", {29'b0, s_valid}, 32'd0);
    chk("to_berr",   {31'b0, buserror}, 32'd1);
    chk("to_rdy",    {31'b0, mem_ready}, 32'd0);
`ifdef SOC_BUS_ERR_CAPTURE_EN
    chk("to_cause", {30'b0, err_cause}, 32'd3);
    chk("to_eaddr", err_addr, 32'h0000_0000);
`endif

    // Reset in WAIT aborts, then a normal read completes.
    do_reset();
    mem_valid = 1'b1; mem_addr = 32'h0001_0000; mem_wstrb = 4'b0000;
    tick();
    chk("ab_sv", {29'b0, s_valid}, 32'b010);
    tick();
    resetn = 1'b0;
    tick();
    chk("ab_sv_off", {29'b0, s_valid}, 32'd0);
    chk("ab_berr",   {31'b0, buserror}, 32'd0);
    chk("ab_rdy",    {31'b0, mem_ready}, 32'd0);
    resetn = 1'b1;
    mem_addr = 32'h0000_0004;
    s_rdata[31:0] = 32'hCAFE_F00D; s_ready = 3'b001;
    tick();
    chk("ab_rd_sv", {29'b0, s_valid}, 32'b001);
    chk("ab_rd_rdy0", {31'b0, mem_ready}, 32'd0);
    tick();
    chk("ab_rd_rdy",   {31'b0, mem_ready}, 32'd1);
    chk("ab_rd_rdata", mem_rdata, 32'hCAFE_F00D);
    mem_valid = 1'b0; s_ready = 3'b000;
    tick();
    chk("ab_rd_rdy_off", {31'b0, mem_ready}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
